// File: rtl/sram_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_mem_pkg
// Description : Shared types and default constants for the MEM-stage SRAM
//               controller: FSM state encoding, default base address and
//               phase length, and the phase-counter width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package arm_mem_pkg;

  // Access sequencer states: idle, low half-word, high half-word, completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } sram_state_t;

  localparam logic [31:0] SRAM_BASE_ADDR    = 32'd1024;
  localparam int          SRAM_PHASE_CYCLES = 2;

  // Wide enough for any legal phase length (1..15).
  localparam int          PHASE_CNT_W       = 4;

endpackage : arm_mem_pkg
`default_nettype wire

// File: rtl/sram_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_controller_if
// Description : Bundles the MEM-stage request/response signals and the
//               external asynchronous SRAM pad signals.
// Ports       : rd_en, wr_en, address, write_data   (pipeline -> controller)
//               read_data, ready                    (controller -> pipeline)
//               sram_addr, sram_dq_o, sram_dq_oe,
//               sram_we_n, sram_oe_n                (controller -> SRAM pad)
//               sram_dq_i                           (SRAM pad -> controller)
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_controller_if #(
  parameter int SRAM_AW = 18
);

  logic               rd_en;
  logic               wr_en;
  logic [31:0]        address;
  logic [31:0]        write_data;
  logic [31:0]        read_data;
  logic               ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_dq_o;
  logic [15:0]        sram_dq_i;
  logic               sram_dq_oe;
  logic               sram_we_n;
  logic               sram_oe_n;

  // Controller side.
  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_i,
    output read_data, ready, sram_addr, sram_dq_o, sram_dq_oe,
           sram_we_n, sram_oe_n
  );

  // Pipeline / pad side.
  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_i,
    input  read_data, ready, sram_addr, sram_dq_o, sram_dq_oe,
           sram_we_n, sram_oe_n
  );

endinterface : sram_controller_if
`default_nettype wire

// File: rtl/sram_phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : sram_phase_counter
// Description : Counts 0..PHASE_CYCLES-1 while enabled and wraps; flags the
//               final count of each half-word phase.
// Ports       : clk, rst (sync, active-high), clear (force count to 0),
//               enable (advance), last (count == PHASE_CYCLES-1)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_phase_counter
  import arm_mem_pkg::*;
#(
  parameter int PHASE_CYCLES = SRAM_PHASE_CYCLES
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clear,
  input  wire logic enable,
  output logic      last
);

  localparam logic [PHASE_CNT_W-1:0] c_last_count = PHASE_CNT_W'(PHASE_CYCLES - 1);

  logic [PHASE_CNT_W-1:0] cnt_q;
  logic [PHASE_CNT_W-1:0] cnt_d;

  assign last = (cnt_q == c_last_count);

  // Wrapping on the final count lets HIGH start at zero straight after LOW.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = last ? '0 : cnt_q + PHASE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : sram_phase_counter
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : sram_controller
// Description : MEM-stage responder that performs one 32-bit load or store
//               as two 16-bit accesses (low half, then high half) on an
//               external asynchronous SRAM. ready is low while an access is
//               pending; the pipeline freezes on ~ready.
// Ports       : clk, rst (sync, active-high)
//               mem (sram_controller_if.slave): request inputs, read_data,
//               ready and the SRAM pad signals
// Revision    : 1.0 - initial release
// ============================================================================
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = SRAM_BASE_ADDR,
  parameter int          PHASE_CYCLES = SRAM_PHASE_CYCLES,
  parameter int          SRAM_AW      = 18
) (
  input  wire logic         clk,
  input  wire logic         rst,
  sram_controller_if.slave  mem
);

  sram_state_t          state_q, state_d;
  logic                 is_wr_q, is_wr_d;
  logic [SRAM_AW-2:0]   word_q,  word_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;

  logic                 w_req;
  logic                 w_busy;
  logic                 w_last;
  logic [31:0]          w_offset;

  assign w_req    = mem.rd_en | mem.wr_en;
  assign w_busy   = (state_q == LOW) || (state_q == HIGH);
  // Modulo-2^32 offset; bits above the SRAM word range are dropped on purpose.
  assign w_offset = mem.address - BASE_ADDR;

  sram_phase_counter #(
    .PHASE_CYCLES (PHASE_CYCLES)
  ) u_phase_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (~w_busy),
    .enable (w_busy),
    .last   (w_last)
  );

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (w_req) begin
          state_d = LOW;
          is_wr_d = mem.wr_en;   // write wins when both enables are high
          word_d  = w_offset[SRAM_AW:2];
          wdata_d = mem.write_data;
        end
      end
      LOW: begin
        if (w_last) begin
          state_d = HIGH;
          if (!is_wr_q) rdata_d[15:0] = mem.sram_dq_i;
        end
      end
      HIGH: begin
        if (w_last) begin
          state_d = DONE;
          if (!is_wr_q) rdata_d[31:16] = mem.sram_dq_i;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Pad signals decode from registered state only, so they are stable for
  // whole phases; the latched address and data keep them at zero after reset.
  assign mem.sram_addr  = {word_q, (state_q == HIGH)};
  assign mem.sram_dq_o  = (state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
  assign mem.sram_dq_oe = w_busy & is_wr_q;
  assign mem.sram_we_n  = ~(w_busy & is_wr_q);
  assign mem.sram_oe_n  = ~(w_busy & ~is_wr_q);
  assign mem.read_data  = rdata_q;
  assign mem.ready      = ((state_q == IDLE) & ~w_req) | (state_q == DONE);

endmodule : sram_controller
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_controller
// Description : Self-checking bench for sram_controller: directed vector
//               table of loads/stores with hand-computed SRAM addresses and
//               load results, plus reset and back-to-back sequences.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

  localparam int P  = 2;
  localparam int AW = 18;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [AW-1:0] exp_lo;
    logic [AW-1:0] exp_hi;
    logic [31:0]   exp_rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sram_controller_if #(.SRAM_AW(AW)) bus ();

  sram_controller #(
    .BASE_ADDR    (32'd1024),
    .PHASE_CYCLES (P),
    .SRAM_AW      (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mem (bus)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM model: writes while strobed, reads while output-enabled.
  logic [15:0] sram_mem [0:(1<<AW)-1];
  bit          preload_done = 1'b0;

  always @(posedge clk) begin
    if (!preload_done) begin
      sram_mem[6]  <= 16'h1111;
      sram_mem[7]  <= 16'h2222;
      preload_done <= 1'b1;
    end else if (!bus.sram_we_n && bus.sram_dq_oe) begin
      sram_mem[bus.sram_addr] <= bus.sram_dq_o;
    end
  end

  assign bus.sram_dq_i = bus.sram_oe_n ? 16'h0000 : sram_mem[bus.sram_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one access starting in an IDLE cycle and checks every cycle of it.
  task automatic run_txn(input vec_t v);
    logic is_w;
    logic hi;
    is_w = v.wr;
    bus.rd_en      = v.rd;
    bus.wr_en      = v.wr;
    bus.address    = v.addr;
    bus.write_data = v.wdata;
    #1;
    chk("ready_cycle0", 32'(bus.ready), 32'd0);
    for (int c = 1; c <= 2 * P; c++) begin
      tick();
      if (c == 1) begin
        // Garbage on the inputs must not disturb the latched request.
        bus.rd_en      = 1'b0;
        bus.wr_en      = 1'b0;
        bus.address    = 32'hFFFF_FFF0;
        bus.write_data = 32'h0BAD_0BAD;
      end
      hi = (c > P);
      chk("ready_busy", 32'(bus.ready), 32'd0);
      chk("sram_addr", 32'(bus.sram_addr), hi ? 32'(v.exp_hi) : 32'(v.exp_lo));
      chk("we_n", 32'(bus.sram_we_n), is_w ? 32'd0 : 32'd1);
      chk("oe_n", 32'(bus.sram_oe_n), is_w ? 32'd1 : 32'd0);
      chk("dq_oe", 32'(bus.sram_dq_oe), is_w ? 32'd1 : 32'd0);
      if (is_w) chk("dq_o", 32'(bus.sram_dq_o), hi ? 32'(v.wdata[31:16]) : 32'(v.wdata[15:0]));
    end
    tick();
    chk("ready_done", 32'(bus.ready), 32'd1);
    chk("we_n_done", 32'(bus.sram_we_n), 32'd1);
    chk("oe_n_done", 32'(bus.sram_oe_n), 32'd1);
    chk("dq_oe_done", 32'(bus.sram_dq_oe), 32'd0);
    chk("read_data", bus.read_data, v.exp_rd);
    tick();
    chk("ready_idle", 32'(bus.ready), 32'd1);
  endtask

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    //        rd    wr    address      wdata          lo         hi         read_data
    vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 18'd0,     18'd1,     32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 18'd0,     18'd1,     32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 32'd1036, 32'h00000000, 18'd6,     18'd7,     32'h22221111};
    vecs[3] = '{1'b1, 1'b1, 32'd1028, 32'h12345678, 18'd2,     18'd3,     32'h22221111};
    vecs[4] = '{1'b1, 1'b0, 32'd1028, 32'h00000000, 18'd2,     18'd3,     32'h12345678};
    vecs[5] = '{1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 18'h3FFFE, 18'h3FFFF, 32'h12345678};
    vecs[6] = '{1'b1, 1'b0, 32'd1020, 32'h00000000, 18'h3FFFE, 18'h3FFFF, 32'hCAFEF00D};

    bus.rd_en      = 1'b0;
    bus.wr_en      = 1'b0;
    bus.address    = 32'd0;
    bus.write_data = 32'd0;

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_read_data", bus.read_data, 32'd0);
    chk("rst_sram_addr", 32'(bus.sram_addr), 32'd0);
    chk("rst_dq_o", 32'(bus.sram_dq_o), 32'd0);
    chk("rst_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
    chk("rst_we_n", 32'(bus.sram_we_n), 32'd1);
    chk("rst_oe_n", 32'(bus.sram_oe_n), 32'd1);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset in the first HIGH cycle of a write abandons it.
    bus.wr_en      = 1'b1;
    bus.address    = 32'd1032;
    bus.write_data = 32'hAAAA5555;
    tick();
    bus.wr_en = 1'b0;
    for (int c = 2; c <= P + 1; c++) tick();
    chk("mid_high_addr", 32'(bus.sram_addr), 32'd5);
    chk("mid_high_we_n", 32'(bus.sram_we_n), 32'd0);
    rst = 1'b1;
    tick();
    chk("mid_rst_we_n", 32'(bus.sram_we_n), 32'd1);
    chk("mid_rst_oe_n", 32'(bus.sram_oe_n), 32'd1);
    chk("mid_rst_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
    chk("mid_rst_ready", 32'(bus.ready), 32'd1);
    chk("mid_rst_addr", 32'(bus.sram_addr), 32'd0);
    chk("mid_rst_read_data", bus.read_data, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_we_n", 32'(bus.sram_we_n), 32'd1);

    // Back-to-back loads with the request held high.
    bus.rd_en   = 1'b1;
    bus.address = 32'd1024;
    #1;
    pulses = 0;
    for (int c = 0; c <= 4 * P + 3; c++) begin
      if (c > 0) tick();
      if (bus.ready) pulses++;
      if (c == 1)         chk("b2b_low1_oe_n", 32'(bus.sram_oe_n), 32'd0);
      if (c == 2 * P + 1) begin
        chk("b2b_done1_ready", 32'(bus.ready), 32'd1);
        chk("b2b_done1_data", bus.read_data, 32'hDEADBEEF);
      end
      if (c == 2 * P + 2) begin
        chk("b2b_idle_oe_n", 32'(bus.sram_oe_n), 32'd1);
        chk("b2b_idle_ready", 32'(bus.ready), 32'd0);
      end
      if (c == 2 * P + 3) begin
        chk("b2b_low2_oe_n", 32'(bus.sram_oe_n), 32'd0);
        chk("b2b_low2_addr", 32'(bus.sram_addr), 32'd0);
      end
      if (c == 4 * P + 3) begin
        chk("b2b_done2_ready", 32'(bus.ready), 32'd1);
        chk("b2b_done2_data", bus.read_data, 32'hDEADBEEF);
      end
    end
    chk("b2b_ready_pulses", 32'(pulses), 32'd2);
    bus.rd_en = 1'b0;
    tick();
    chk("b2b_final_idle_ready", 32'(bus.ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sram_controller
`default_nettype wire
